// File: rtl/mips_instr_writer.sv
// rtl/mips_instr_writer.sv - MIPS R/I/J word assembler and 64-word instruction store writer
// Optional opcode legality checking is enabled by defining MIPS_WR_LEGAL_CHECK_EN.
module mips_instr_writer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [1:0]    i_fmt,
  input  logic [5:0]    i_op,
  input  logic [4:0]    i_rs,
  input  logic [4:0]    i_rt,
  input  logic [4:0]    i_rd,
  input  logic [4:0]    i_shamt,
  input  logic [5:0]    i_funct,
  input  logic [15:0]   i_imm,
  input  logic [25:0]   i_target,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data,
  output logic [AW-1:0] o_wr_ptr,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_err,
  output logic [2:0]    o_cnt_r,
  output logic [2:0]    o_cnt_i,
  output logic [1:0]    o_cnt_j
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WRITE} state_t;

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

  state_t r_state, w_state_nxt;

  logic [1:0]  r_fmt;
  logic [5:0]  r_op, r_funct;
  logic [4:0]  r_rs, r_rt, r_rd, r_shamt;
  logic [15:0] r_imm;
  logic [25:0] r_target;

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_rd_data;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_level;
  logic          r_err;
  logic [2:0]    r_cnt_r, r_cnt_i;
  logic [1:0]    r_cnt_j;

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_accept;
  logic        w_commit;
  logic        w_reject;

  assign o_full     = (r_level == LVL_MAX);
  assign o_in_ready = (r_state == S_IDLE) && !o_full;
  assign w_accept   = i_in_valid && o_in_ready && !i_clear;
  assign w_commit   = (r_state == S_WRITE) && !i_clear;
  assign w_reject   = (r_state == S_ENC) && !w_legal && !i_clear;

  always_comb begin
    w_word = {r_op, r_target};
    case (r_fmt)
      2'd0:    w_word = {r_op, r_rs, r_rt, r_rd, r_shamt, r_funct};
      2'd1:    w_word = {r_op, r_rs, r_rt, r_imm};
      default: w_word = {r_op, r_target};
    endcase
  end

`ifdef MIPS_WR_LEGAL_CHECK_EN
  // REGIMM (0x01) never reaches the store, whatever the format claims.
  always_comb begin
    w_legal = 1'b0;
    case (r_fmt)
      2'd0:    w_legal = (r_op == 6'h00);
      2'd1:    w_legal = (r_op[5:2] != 4'h0);
      2'd2:    w_legal = (r_op == 6'h02) || (r_op == 6'h03);
      default: w_legal = 1'b0;
    endcase
    if (r_op == 6'h01) w_legal = 1'b0;
  end
`else
  always_comb begin
    w_legal = (r_fmt != 2'd3);
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ENC;
      S_ENC:   w_state_nxt = w_legal ? S_WRITE : S_IDLE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_clear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fmt    <= 2'd0;
      r_op     <= 6'd0;
      r_rs     <= 5'd0;
      r_rt     <= 5'd0;
      r_rd     <= 5'd0;
      r_shamt  <= 5'd0;
      r_funct  <= 6'd0;
      r_imm    <= 16'd0;
      r_target <= 26'd0;
    end else if (w_accept) begin
      r_fmt    <= i_fmt;
      r_op     <= i_op;
      r_rs     <= i_rs;
      r_rt     <= i_rt;
      r_rd     <= i_rd;
      r_shamt  <= i_shamt;
      r_funct  <= i_funct;
      r_imm    <= i_imm;
      r_target <= i_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_err    <= 1'b0;
      r_cnt_r  <= 3'd0;
      r_cnt_i  <= 3'd0;
      r_cnt_j  <= 2'd0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_err    <= 1'b0;
      r_cnt_r  <= 3'd0;
      r_cnt_i  <= 3'd0;
      r_cnt_j  <= 2'd0;
    end else begin
      if (w_reject) r_err <= 1'b1;
      if (w_commit) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        r_level  <= r_level + LVL_ONE;
        case (r_fmt)
          2'd0:    r_cnt_r <= r_cnt_r + 3'd1;
          2'd1:    r_cnt_i <= r_cnt_i + 3'd1;
          2'd2:    r_cnt_j <= r_cnt_j + 2'd1;
          default: ;
        endcase
      end
    end
  end

  // Storage array has no reset so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_commit && i_rst_n) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rd_data <= 32'd0;
    else          r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
  assign o_wr_ptr  = r_wr_ptr;
  assign o_level   = r_level;
  assign o_err     = r_err;
  assign o_cnt_r   = r_cnt_r;
  assign o_cnt_i   = r_cnt_i;
  assign o_cnt_j   = r_cnt_j;

endmodule

// File: doc/mips_instr_writer.md
# mips_instr_writer

Instruction-memory writer: the producing end of the 64-word MIPS instruction store that the instruction counter fetches from. It accepts decoded instruction fields over a valid/ready handshake and assembles R, I and J format words. It checks opcode/format legality and appends each legal word to a 64-entry memory at an incrementing write pointer. A registered read port serves the fetch side, and per-format write counters use the same widths as the counter's tallies.

## Interface
- `DEPTH`, 64: memory words. Must be a power of two.
- `AW`, 6: address width, log2(DEPTH).
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous clear of pointer, level, counters and `err`; memory contents kept
- `in_valid`  in  1  field bundle valid
- `in_ready`  out  1  writer can accept a bundle
- `fmt`  in  2  0=R, 1=I, 2=J, 3=reserved
- `op`  in  6  opcode [31:26]
- `rs`, `rt`, `rd`, `shamt`  in  5 each  register/shift fields
- `funct`  in  6  R function field
- `imm`  in  16  I immediate
- `target`  in  26  J target
- `rd_addr`  in  AW  fetch address
- `rd_data`  out  32  registered memory read
- `wr_ptr`  out  AW  next write address
- `level`  out  AW+1  words written since reset/clear
- `full`  out  1  `level == DEPTH`
- `err`  out  1  sticky illegal-bundle flag
- `cnt_r`  out  3  R words written, wraps mod 8
- `cnt_i`  out  3  I words written, wraps mod 8
- `cnt_j`  out  2  J words written, wraps mod 4

## Operation
- The FSM has three states:
  - IDLE: `in_ready = !full`.
  - ENC: the latched bundle is assembled and checked.
  - WRITE: the word is stored.
- IDLE→ENC on `in_valid && in_ready`. The bundle is latched on that edge.
- ENC→WRITE if the bundle is legal. Otherwise `err` is set to 1, the bundle is discarded, and the FSM returns to IDLE.
- WRITE→IDLE always. On that edge:
  - `mem[wr_ptr]` ← word.
  - `wr_ptr` increments, wrapping to 0 when DEPTH is reached.
  - `level` increments.
  - The matching format counter increments.
- Word assembly:
  - R: `{op, rs, rt, rd, shamt, funct}`.
  - I: `{op, rs, rt, imm}`.
  - J: `{op, target}`.
- Legality rules:
  - `fmt=3` is always illegal.
  - R requires `op==0`.
  - J requires `op` ∈ {0x02, 0x03}.
  - I requires `op` ∉ {0x00, 0x01, 0x02, 0x03}.
  - Opcode 0x01 (REGIMM) is illegal in every format.
- `full` blocks acceptance. The pointer does not wrap over live data until `clear`.
- `clear` behaviour:
  - Takes effect in any state, on the next edge.
  - Zeroes `wr_ptr`, `level`, the counters and `err`, and forces IDLE.
  - If asserted during ENC or WRITE, it aborts the pending write; memory is not modified on that edge.
  - `clear` outranks a simultaneous handshake; no bundle is accepted on that edge.
- `rd_data` ← `mem[rd_addr]` on every edge, independent of FSM state.
- Reset: FSM=IDLE, `wr_ptr=0`, `level=0`, `full=0`, `err=0`, all counters 0, `rd_data=0`, `in_ready=1`. Memory contents are not reset.

## Timing
- Handshake at edge of cycle 0.
- ENC occupies cycle 1.
- Memory is written at the edge ending cycle 2. `wr_ptr`, `level` and the counters update at that same edge.
- `in_ready` is 0 in cycles 1–2 and returns to 1 in cycle 3. Peak throughput is one bundle per 3 cycles.
- `err` rises at the edge ending cycle 1 for an illegal bundle. `in_ready` returns in cycle 2.
- Read latency is 1 cycle. A read of an address written at the edge ending cycle 2 returns new data when `rd_addr` is presented in cycle ≥3. Same-edge write and read of one address returns old data.
- `full` asserts combinationally from `level` in the cycle after the 64th write edge.
- Asserting `rst_n` low mid-ENC or mid-WRITE immediately returns all outputs to their reset values. No partial write occurs.

## Configuration
- `MIPS_WR_LEGAL_CHECK_EN` defined: legality rules apply as above; `err` is functional.
- Not defined: only `fmt=3` is rejected (sets `err`). Every R/I/J bundle is written regardless of `op`, and the format counter follows `fmt`.

## Test plan
- Reset, then I bundle op=0x08, rs=0, rt=4, imm=0x3456 → after 3 cycles: `mem[0]=0x20043456`, `wr_ptr=1`, `cnt_i=1`; `rd_addr=0` → `rd_data=0x20043456` one cycle later.
- R bundle op=0, rs=5, rt=4, rd=6, shamt=0, funct=0x20, then J bundle op=0x02, target=0x1234567 → `mem[0]=0x00A43020`, `mem[1]=0x09234567`, `cnt_r=1`, `cnt_j=1`, `level=2`.
- R bundle with op=0x08 (macro on) → `err=1`, `wr_ptr`/`level`/counters unchanged, `in_ready` back high 2 cycles after handshake. With macro off, word `0x20...` is written and `cnt_r=1`.
- 64 legal I bundles → `level=64`, `full=1`, `in_ready=0`, 65th `in_valid` ignored, `cnt_i=0` (wrapped); `clear` → `wr_ptr=0`, `full=0`, `mem[0]` unchanged.
- Handshake, then `clear` in the ENC cycle → no write, FSM IDLE, `level=0`. Repeat with `rst_n` low in the WRITE cycle → all outputs at reset values, target word unchanged.
- Back-to-back `in_valid` held high with 9 J bundles → acceptances exactly 3 cycles apart, `cnt_j=1` (9 mod 4).
